rx_eth_frame_parser: RTL

//  Sits directly downstream of rx_mac_top and consumes its registered byte stream plus per-byte field flags.

---
 rtl/rx_eth_frame_parser_pkg.sv | 37 +++
 rtl/rx_eth_frame_parser_fcs_strip_buffer.sv | 54 +++++
 rtl/rx_eth_frame_parser.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_eth_frame_parser_pkg.sv
// ============================================================================
// rx_eth_frame_parser_pkg : shared types and constants for the Rx frame parser
// Revision 1.0
// ============================================================================
`default_nettype none

package rx_eth_frame_parser_pkg;

  localparam int MAC_ADDR_W   = 48;
  localparam int ETHER_TYPE_W = 16;
  localparam int FCS_BYTES    = 4;
  localparam int HDR_BYTES    = 14;
  localparam int PAY_CNT_W    = 11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    HEADER   = 3'd2,
    PAYLOAD  = 3'd3,
    DROP     = 3'd4
  } parser_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_INVALID  = 2'd1,
    ERR_TRUNC    = 2'd2,
    ERR_OVERSIZE = 2'd3
  } frame_err_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [PAY_CNT_W-1:0] sat_inc(input logic [PAY_CNT_W-1:0] v);
    return (v == {PAY_CNT_W{1'b1}}) ? v : v + {{(PAY_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_eth_frame_parser_fcs_strip_buffer.sv
// ============================================================================
// fcs_strip_buffer : (FCS_BYTES+1)-deep byte shift register with fill count
// Revision 1.0
// ============================================================================
`default_nettype none

module fcs_strip_buffer
  import rx_eth_frame_parser_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = FCS_BYTES + 1,
  parameter int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] oldest_o,
  output logic [FILL_W-1:0] fill_o
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [FILL_W-1:0]            fill_q;

  // Oldest entry is only meaningful while the buffer is full; that is the
  // only time the parser reads it.
  assign oldest_o = mem_q[DEPTH-1];
  assign fill_o   = fill_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q  <= '0;
      fill_q <= '0;
    end else begin
      if (shift_i) begin
        mem_q <= {mem_q[DEPTH-2:0], data_i};
      end
      if (flush_i) begin
        fill_q <= '0;
      end else if (shift_i && !pop_i) begin
        if (fill_q != FILL_W'(DEPTH)) begin
          fill_q <= fill_q + FILL_W'(1);
        end
      end else if (pop_i && !shift_i && (fill_q != '0)) begin
        fill_q <= fill_q - FILL_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rx_eth_frame_parser.sv
// ============================================================================
// rx_eth_frame_parser : header capture, FCS-stripped payload stream, aborts
// Revision 1.0
// ============================================================================
`default_nettype none

module rx_eth_frame_parser
  import rx_eth_frame_parser_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int FCS_BYTES   = 4,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       rx_data_i,
  input  logic                    rx_data_valid_i,
  input  logic                    is_preamble_or_sfd_i,
  input  logic                    is_dst_mac_i,
  input  logic                    is_src_mac_i,
  input  logic                    is_ether_type_i,
  input  logic                    is_payload_or_crc_i,
  input  logic                    invalid_frame_i,
  output logic [MAC_ADDR_W-1:0]   dst_mac_o,
  output logic [MAC_ADDR_W-1:0]   src_mac_o,
  output logic [ETHER_TYPE_W-1:0] ether_type_o,
  output logic                    header_valid_o,
  output logic [DATA_W-1:0]       payload_data_o,
  output logic                    payload_valid_o,
  output logic                    payload_sop_o,
  output logic                    payload_eop_o,
  output logic                    payload_err_o,
  output logic                    frame_error_o,
  output logic [1:0]              error_code_o
);

  localparam int                   BUF_DEPTH = FCS_BYTES + 1;
  localparam int                   FILL_W    = $clog2(BUF_DEPTH + 1);
  localparam int                   HDR_W     = HDR_BYTES * DATA_W;
  localparam logic [3:0]           HDR_LAST  = 4'(HDR_BYTES - 1);
  localparam logic [PAY_CNT_W-1:0] PAY_LIMIT = PAY_CNT_W'(MAX_PAYLOAD + FCS_BYTES);

  parser_state_t          state_q, state_d;
  logic [3:0]             hdr_cnt_q, hdr_cnt_d;
  logic [HDR_W-1:0]       hdr_sh_q, hdr_sh_d;
  logic [PAY_CNT_W-1:0]   pay_cnt_q, pay_cnt_d;
  logic                   sop_sent_q, sop_sent_d;

  logic [MAC_ADDR_W-1:0]   dst_mac_q, dst_mac_d;
  logic [MAC_ADDR_W-1:0]   src_mac_q, src_mac_d;
  logic [ETHER_TYPE_W-1:0] ether_type_q, ether_type_d;
  logic                    header_valid_q, header_valid_d;
  logic [DATA_W-1:0]       pay_data_q, pay_data_d;
  logic                    pay_valid_q, pay_valid_d;
  logic                    pay_sop_q, pay_sop_d;
  logic                    pay_eop_q, pay_eop_d;
  logic                    pay_err_q, pay_err_d;
  logic                    frame_error_q, frame_error_d;
  frame_err_t              error_code_q, error_code_d;

  logic                    err_det;
  frame_err_t              err_kind;
  logic                    hdr_take;
  logic                    hdr_done;
  logic                    pay_shift;
  logic                    norm_end;
  logic                    hdr_flag_ok;
  logic                    buf_full;
  logic                    emit_norm;
  logic [DATA_W-1:0]       buf_oldest;
  logic [FILL_W-1:0]       buf_fill;

  fcs_strip_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH),
    .FILL_W (FILL_W)
  ) u_fcs_buf (
    .clk      (clk),
    .rst      (rst),
    .shift_i  (pay_shift),
    .pop_i    (norm_end),
    .flush_i  (err_det | hdr_done),
    .data_i   (rx_data_i),
    .oldest_o (buf_oldest),
    .fill_o   (buf_fill)
  );

  assign buf_full    = (buf_fill == FILL_W'(BUF_DEPTH));
  assign hdr_flag_ok = (hdr_cnt_q < 4'd6)  ? is_dst_mac_i :
                       (hdr_cnt_q < 4'd12) ? is_src_mac_i : is_ether_type_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    err_det   = 1'b0;
    err_kind  = ERR_NONE;
    hdr_take  = 1'b0;
    hdr_done  = 1'b0;
    pay_shift = 1'b0;
    norm_end  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_data_valid_i) begin
          state_d = is_preamble_or_sfd_i ? PREAMBLE : DROP;
        end
      end
      PREAMBLE: begin
        if (invalid_frame_i) begin
          err_det = 1'b1; err_kind = ERR_INVALID;
        end else if (!rx_data_valid_i) begin
          err_det = 1'b1; err_kind = ERR_TRUNC;
        end else if (is_dst_mac_i) begin
          state_d  = HEADER;
          hdr_take = 1'b1;
        end else if (!is_preamble_or_sfd_i) begin
          err_det = 1'b1; err_kind = ERR_TRUNC;
        end
      end
      HEADER: begin
        if (invalid_frame_i) begin
          err_det = 1'b1; err_kind = ERR_INVALID;
        end else if (!rx_data_valid_i || !hdr_flag_ok) begin
          err_det = 1'b1; err_kind = ERR_TRUNC;
        end else begin
          hdr_take = 1'b1;
          if (hdr_cnt_q == HDR_LAST) begin
            hdr_done = 1'b1;
            state_d  = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        // The count is checked registered, so the byte that crosses the
        // limit still pushes one normal beat before the abort.
        if (invalid_frame_i) begin
          err_det = 1'b1; err_kind = ERR_INVALID;
        end else if (pay_cnt_q > PAY_LIMIT) begin
          err_det = 1'b1; err_kind = ERR_OVERSIZE;
        end else if (!rx_data_valid_i) begin
          if (buf_full) begin
            norm_end = 1'b1;
            state_d  = IDLE;
          end else begin
            err_det = 1'b1; err_kind = ERR_TRUNC;
          end
        end else if (!is_payload_or_crc_i) begin
          err_det = 1'b1; err_kind = ERR_TRUNC;
        end else begin
          pay_shift = 1'b1;
        end
      end
      DROP: begin
        if (!rx_data_valid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // An error seen while valid is already low has found the inter-frame
    // gap, so skip DROP and be ready for a frame starting next cycle.
    if (err_det) begin
      state_d = rx_data_valid_i ? DROP : IDLE;
    end
  end

  assign emit_norm = (pay_shift && buf_full) || norm_end;

  always_comb begin
    hdr_sh_d  = hdr_sh_q;
    hdr_cnt_d = hdr_cnt_q;
    pay_cnt_d = pay_cnt_q;
    if (hdr_take) begin
      hdr_sh_d  = {hdr_sh_q[HDR_W-DATA_W-1:0], rx_data_i};
      hdr_cnt_d = hdr_cnt_q + 4'd1;
    end
    if (state_d != HEADER) begin
      hdr_cnt_d = '0;
    end
    if (hdr_done) begin
      pay_cnt_d = '0;
    end else if (pay_shift) begin
      pay_cnt_d = sat_inc(pay_cnt_q);
    end

    header_valid_d = hdr_done;
    dst_mac_d      = dst_mac_q;
    src_mac_d      = src_mac_q;
    ether_type_d   = ether_type_q;
    if (hdr_done) begin
      dst_mac_d    = hdr_sh_d[ETHER_TYPE_W+MAC_ADDR_W +: MAC_ADDR_W];
      src_mac_d    = hdr_sh_d[ETHER_TYPE_W +: MAC_ADDR_W];
      ether_type_d = hdr_sh_d[0 +: ETHER_TYPE_W];
    end

    pay_data_d  = '0;
    pay_valid_d = 1'b0;
    pay_sop_d   = 1'b0;
    pay_eop_d   = 1'b0;
    pay_err_d   = 1'b0;
    if (err_det && sop_sent_q) begin
      pay_valid_d = 1'b1;
      pay_eop_d   = 1'b1;
      pay_err_d   = 1'b1;
    end else if (emit_norm) begin
      pay_valid_d = 1'b1;
      pay_data_d  = buf_oldest;
      pay_sop_d   = !sop_sent_q;
      pay_eop_d   = norm_end;
    end
    sop_sent_d = (state_d == PAYLOAD) && (sop_sent_q || emit_norm);

    frame_error_d = err_det;
    error_code_d  = err_det ? err_kind : error_code_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hdr_sh_q       <= '0;
      hdr_cnt_q      <= '0;
      pay_cnt_q      <= '0;
      sop_sent_q     <= 1'b0;
      dst_mac_q      <= '0;
      src_mac_q      <= '0;
      ether_type_q   <= '0;
      header_valid_q <= 1'b0;
      pay_data_q     <= '0;
      pay_valid_q    <= 1'b0;
      pay_sop_q      <= 1'b0;
      pay_eop_q      <= 1'b0;
      pay_err_q      <= 1'b0;
      frame_error_q  <= 1'b0;
      error_code_q   <= ERR_NONE;
    end else begin
      hdr_sh_q       <= hdr_sh_d;
      hdr_cnt_q      <= hdr_cnt_d;
      pay_cnt_q      <= pay_cnt_d;
      sop_sent_q     <= sop_sent_d;
      dst_mac_q      <= dst_mac_d;
      src_mac_q      <= src_mac_d;
      ether_type_q   <= ether_type_d;
      header_valid_q <= header_valid_d;
      pay_data_q     <= pay_data_d;
      pay_valid_q    <= pay_valid_d;
      pay_sop_q      <= pay_sop_d;
      pay_eop_q      <= pay_eop_d;
      pay_err_q      <= pay_err_d;
      frame_error_q  <= frame_error_d;
      error_code_q   <= error_code_d;
    end
  end

  assign dst_mac_o       = dst_mac_q;
  assign src_mac_o       = src_mac_q;
  assign ether_type_o    = ether_type_q;
  assign header_valid_o  = header_valid_q;
  assign payload_data_o  = pay_data_q;
  assign payload_valid_o = pay_valid_q;
  assign payload_sop_o   = pay_sop_q;
  assign payload_eop_o   = pay_eop_q;
  assign payload_err_o   = pay_err_q;
  assign frame_error_o   = frame_error_q;
  assign error_code_o    = error_code_q;

endmodule

`default_nettype wire
